// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter
//
// Two-requester arbiter and transaction sequencer for the OLED SPI byte buffer.
// Requester 0 (command/config engine) and requester 1 (pixel/draw engine) each
// present a packet of up to N bytes with per-byte D/C bits. One requester is
// granted at a time. Its packet is copied into the downstream buffer inputs
// and a start pulse is issued. The block then waits for the buffer's
// final-byte flag, holds an inter-packet chip-select gap, and reports
// completion (or timeout) to the owner.
//
// Optional feature: define OLED_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests. When it is undefined, requester 0 always wins a tie.
//
// Ports
//   i_CLK               clock, rising edge
//   i_RST               asynchronous, active-high reset
//   i_REQ0 / i_REQ1     request, held until ACK
//   i_DATA0 / i_DATA1   packet bytes, byte 0 in bits [WIDTH-1:0]
//   i_DC0 / i_DC1       D/C bit per byte
//   i_LEN0 / i_LEN1     bytes to send, 0..N (larger values clamp to N)
//   i_FINAL_BYTE        buffer final-byte flag
//   o_ACK0 / o_ACK1     one-cycle pulse, packet captured
//   o_DONE0 / o_DONE1   one-cycle pulse, packet finished or aborted
//   o_ERR               one-cycle pulse alongside DONE on timeout
//   o_DATA / o_DC / o_N packet, D/C bits and byte count to the buffer
//   o_START             one-cycle start pulse to the buffer
//   o_BUSY              high in any state except IDLE
//   o_OWNER             index of current/last granted requester
module oled_spi_arbiter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N          = 8,
    parameter int unsigned LENW       = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_REQ0,
    input  logic                 i_REQ1,
    input  logic [WIDTH*N-1:0]   i_DATA0,
    input  logic [WIDTH*N-1:0]   i_DATA1,
    input  logic [N-1:0]         i_DC0,
    input  logic [N-1:0]         i_DC1,
    input  logic [LENW-1:0]      i_LEN0,
    input  logic [LENW-1:0]      i_LEN1,
    input  logic                 i_FINAL_BYTE,
    output logic                 o_ACK0,
    output logic                 o_ACK1,
    output logic                 o_DONE0,
    output logic                 o_DONE1,
    output logic                 o_ERR,
    output logic [WIDTH*N-1:0]   o_DATA,
    output logic [N-1:0]         o_DC,
    output logic [LENW-1:0]      o_N,
    output logic                 o_START,
    output logic                 o_BUSY,
    output logic                 o_OWNER
);

    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [LENW-1:0]  LEN_MAX  = LENW'(N);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StGap
    } state_e;

    state_e            state_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    // A zero-length packet was acknowledged; its DONE goes out next cycle.
    logic              zero_pend_q;

`ifdef OLED_ARB_ROUND_ROBIN_EN
    // Requester preferred on the next tie.
    logic              rr_ptr_q;
`endif

    // ------------------------------------------------------------------
    // Winner selection and payload mux
    // ------------------------------------------------------------------
    logic                req_any;
    logic                win;
    logic [WIDTH*N-1:0]  win_data;
    logic [N-1:0]        win_dc;
    logic [LENW-1:0]     win_len;
    logic [LENW-1:0]     win_len_clamped;

    always_comb begin
        req_any = i_REQ0 | i_REQ1;
`ifdef OLED_ARB_ROUND_ROBIN_EN
        if (i_REQ0 && i_REQ1) begin
            win = rr_ptr_q;
        end else begin
            win = ~i_REQ0;
        end
`else
        win = ~i_REQ0;
`endif
        win_data        = win ? i_DATA1 : i_DATA0;
        win_dc          = win ? i_DC1   : i_DC0;
        win_len         = win ? i_LEN1  : i_LEN0;
        win_len_clamped = (win_len > LEN_MAX) ? LEN_MAX : win_len;
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= StIdle;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            zero_pend_q <= 1'b0;
`ifdef OLED_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= 1'b0;
`endif
            o_ACK0      <= 1'b0;
            o_ACK1      <= 1'b0;
            o_DONE0     <= 1'b0;
            o_DONE1     <= 1'b0;
            o_ERR       <= 1'b0;
            o_DATA      <= '0;
            o_DC        <= '0;
            o_N         <= '0;
            o_START     <= 1'b0;
            o_BUSY      <= 1'b0;
            o_OWNER     <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            o_ACK0  <= 1'b0;
            o_ACK1  <= 1'b0;
            o_DONE0 <= 1'b0;
            o_DONE1 <= 1'b0;
            o_ERR   <= 1'b0;
            o_START <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (zero_pend_q) begin
                        // Finish the empty packet; requests wait one cycle.
                        zero_pend_q <= 1'b0;
                        o_DONE0     <= ~o_OWNER;
                        o_DONE1     <= o_OWNER;
                    end else if (req_any) begin
                        o_OWNER <= win;
                        o_ACK0  <= ~win;
                        o_ACK1  <= win;
                        o_DATA  <= win_data;
                        o_DC    <= win_dc;
                        o_N     <= win_len_clamped;
`ifdef OLED_ARB_ROUND_ROBIN_EN
                        rr_ptr_q <= ~win;
`endif
                        if (win_len == '0) begin
                            zero_pend_q <= 1'b1;
                        end else begin
                            o_START  <= 1'b1;
                            o_BUSY   <= 1'b1;
                            to_cnt_q <= '0;
                            state_q  <= StWait;
                        end
                    end
                end

                StWait: begin
                    // to_cnt_q is zero only on the first WAIT cycle, where the
                    // buffer's flag may still reflect the previous packet.
                    if ((to_cnt_q != '0) && i_FINAL_BYTE) begin
                        o_DONE0   <= ~o_OWNER;
                        o_DONE1   <= o_OWNER;
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end else if (to_cnt_q == TO_LAST) begin
                        o_DONE0   <= ~o_OWNER;
                        o_DONE1   <= o_OWNER;
                        o_ERR     <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                StGap: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        o_BUSY  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                default: begin
                    o_BUSY  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Randomized bench for oled_spi_arbiter. A transaction-level model predicts,
// for every clock edge, which requester is granted, when its packet finishes
// (from the planned final-byte window and the timeout limit) and how long the
// block stays busy, then compares every output each cycle.
module tb_oled_spi_arbiter;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned N          = 8;
    localparam int unsigned LENW       = 4;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 16;
    localparam int          NCYC       = 4000;

    logic                i_CLK = 1'b0;
    logic                i_RST;
    logic                i_REQ0, i_REQ1;
    logic [WIDTH*N-1:0]  i_DATA0, i_DATA1;
    logic [N-1:0]        i_DC0, i_DC1;
    logic [LENW-1:0]     i_LEN0, i_LEN1;
    logic                i_FINAL_BYTE;
    logic                o_ACK0, o_ACK1, o_DONE0, o_DONE1, o_ERR;
    logic [WIDTH*N-1:0]  o_DATA;
    logic [N-1:0]        o_DC;
    logic [LENW-1:0]     o_N;
    logic                o_START, o_BUSY, o_OWNER;

    always #5 i_CLK = ~i_CLK;

    oled_spi_arbiter #(
        .WIDTH      (WIDTH),
        .N          (N),
        .LENW       (LENW),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_REQ0       (i_REQ0),
        .i_REQ1       (i_REQ1),
        .i_DATA0      (i_DATA0),
        .i_DATA1      (i_DATA1),
        .i_DC0        (i_DC0),
        .i_DC1        (i_DC1),
        .i_LEN0       (i_LEN0),
        .i_LEN1       (i_LEN1),
        .i_FINAL_BYTE (i_FINAL_BYTE),
        .o_ACK0       (o_ACK0),
        .o_ACK1       (o_ACK1),
        .o_DONE0      (o_DONE0),
        .o_DONE1      (o_DONE1),
        .o_ERR        (o_ERR),
        .o_DATA       (o_DATA),
        .o_DC         (o_DC),
        .o_N          (o_N),
        .o_START      (o_START),
        .o_BUSY       (o_BUSY),
        .o_OWNER      (o_OWNER)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester stimulus
    logic               req  [2];
    logic [WIDTH*N-1:0] data [2];
    logic [N-1:0]       dc   [2];
    logic [LENW-1:0]    len  [2];

    // Model state; edges are numbered from the last reset release.
    int              cyc;
    int              next_free;          // earliest edge a grant may happen
    int              g_edge;             // edge of last grant
    int              g_win;
    int              g_len;
    int              done_at;            // edge at which DONE appears
    int              done_own;
    bit              done_err;
    int              busy_lo, busy_hi;   // busy after edges busy_lo..busy_hi-1
    int              fin_lo, fin_hi;     // FINAL driven high on edges fin_lo..fin_hi-1
    int              ptr;                // round-robin preference
    logic [63:0]     m_data;
    logic [N-1:0]    m_dc;
    logic [LENW-1:0] m_n;
    int              m_owner;
    bit              did_rst;

    task automatic new_payload(input int r);
        data[r] = {$urandom, $urandom};
        dc[r]   = N'($urandom);
        len[r]  = ($urandom % 6 == 0) ? LENW'(0) : LENW'($urandom_range(1, 15));
    endtask

    task automatic drive_reqs();
        i_REQ0 = req[0]; i_DATA0 = data[0]; i_DC0 = dc[0]; i_LEN0 = len[0];
        i_REQ1 = req[1]; i_DATA1 = data[1]; i_DC1 = dc[1]; i_LEN1 = len[1];
    endtask

    task automatic model_reset();
        next_free = cyc + 1;
        g_edge    = -100; g_win = 0; g_len = 0;
        done_at   = -100; done_own = 0; done_err = 1'b0;
        busy_lo   = 0; busy_hi = 0;
        fin_lo    = -100; fin_hi = -100;
        ptr       = 0;
        m_data    = '0; m_dc = '0; m_n = '0; m_owner = 0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ack0"},  o_ACK0,  0);
        check_val({tag, "_ack1"},  o_ACK1,  0);
        check_val({tag, "_done0"}, o_DONE0, 0);
        check_val({tag, "_done1"}, o_DONE1, 0);
        check_val({tag, "_err"},   o_ERR,   0);
        check_val({tag, "_data"},  o_DATA,  0);
        check_val({tag, "_dc"},    o_DC,    0);
        check_val({tag, "_n"},     o_N,     0);
        check_val({tag, "_start"}, o_START, 0);
        check_val({tag, "_busy"},  o_BUSY,  0);
        check_val({tag, "_owner"}, o_OWNER, 0);
    endtask

    task automatic compare_all();
        check_val("ack0",  o_ACK0,  (g_edge == cyc && g_win == 0));
        check_val("ack1",  o_ACK1,  (g_edge == cyc && g_win == 1));
        check_val("start", o_START, (g_edge == cyc && g_len != 0));
        check_val("done0", o_DONE0, (done_at == cyc && done_own == 0));
        check_val("done1", o_DONE1, (done_at == cyc && done_own == 1));
        check_val("err",   o_ERR,   (done_at == cyc && done_err));
        check_val("busy",  o_BUSY,  (cyc >= busy_lo && cyc < busy_hi));
        check_val("owner", o_OWNER, 64'(m_owner));
        check_val("data",  o_DATA,  m_data);
        check_val("dc",    o_DC,    m_dc);
        check_val("n",     o_N,     m_n);
    endtask

    initial begin
        int e;
        int win;
        int first;
        for (int r = 0; r < 2; r++) begin
            req[r] = 1'b0;
            new_payload(r);
        end
        drive_reqs();
        i_FINAL_BYTE = 1'b0;
        i_RST        = 1'b1;
        did_rst      = 1'b0;
        #1;
        check_zero("por");
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_RST = 1'b0;
        cyc   = 0;
        model_reset();

        for (int it = 0; it < NCYC; it++) begin
            @(negedge i_CLK);

            // Mid-packet reset with requester 0 waiting.
            if (!did_rst && it > 1500 && g_len != 0 && cyc >= g_edge && cyc < done_at) begin
                did_rst = 1'b1;
                i_RST   = 1'b1;
                #1;
                check_zero("rst_async");
                req[0] = 1'b1;
                new_payload(0);
                if (len[0] == 0) len[0] = 4'd5;
                drive_reqs();
                i_FINAL_BYTE = 1'b0;
                @(posedge i_CLK);
                cyc++;
                #1;
                check_zero("rst_hold");
                @(negedge i_CLK);
                i_RST = 1'b0;
                model_reset();
            end else begin
                for (int r = 0; r < 2; r++) begin
                    if (g_edge == cyc && g_win == r) begin
                        if ($urandom % 2 == 0) req[r] = 1'b0;
                        else new_payload(r);
                    end else if (!req[r] && $urandom % 3 == 0) begin
                        req[r] = 1'b1;
                        new_payload(r);
                    end
                end
            end
            drive_reqs();

            // Predict the coming edge.
            e = cyc + 1;
            if (e >= next_free && (req[0] || req[1])) begin
                if (req[0] && req[1]) begin
`ifdef OLED_ARB_ROUND_ROBIN_EN
                    win = ptr;
`else
                    win = 0;
`endif
                end else begin
                    win = req[0] ? 0 : 1;
                end
                ptr     = 1 - win;
                g_edge  = e;
                g_win   = win;
                g_len   = int'(len[win]);
                m_owner = win;
                m_data  = data[win];
                m_dc    = dc[win];
                m_n     = (len[win] > LENW'(N)) ? LENW'(N) : len[win];
                if (g_len == 0) begin
                    done_at   = e + 1;
                    done_own  = win;
                    done_err  = 1'b0;
                    next_free = e + 2;
                end else begin
                    fin_lo = e + $urandom_range(0, 22);
                    fin_hi = fin_lo + $urandom_range(1, 3);
                    first  = (fin_lo > e + 2) ? fin_lo : e + 2;
                    if (first < fin_hi && first <= e + TIMEOUT) begin
                        done_at  = first;
                        done_err = 1'b0;
                    end else begin
                        done_at  = e + TIMEOUT;
                        done_err = 1'b1;
                    end
                    done_own  = win;
                    busy_lo   = e;
                    busy_hi   = done_at + GAP_CYCLES;
                    next_free = done_at + GAP_CYCLES + 1;
                end
            end

            // FINAL: planned window, plus noise where the arbiter must ignore it.
            i_FINAL_BYTE = (e >= fin_lo && e < fin_hi)
                        || (e > done_at && $urandom % 4 == 0)
                        || (g_len != 0 && e == g_edge + 1 && $urandom % 2 == 0);

            @(posedge i_CLK);
            cyc++;
            #1;
            compare_all();
        end

        if (!did_rst) check_val("rst_reached", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
